// File: rtl/fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// fifo_burst_reader
//
// Pulls words from a show-ahead FIFO in bursts and presents them on a
// valid/ready stream with a last marker on the final word of each burst.
//
// A burst starts from IDLE in one of two ways:
//   * the FIFO reports it is not almost-empty: a full burst of burst_len words
//   * the FIFO has held data for timeout idle cycles: a single-word burst
//     that flushes a stragglers word
//
// Popped words land in a 2-entry output buffer, so the reader can pop and
// hand off one word per cycle while still absorbing downstream backpressure
// without losing words.
//
// Ports
//   clk               single clock, rising edge
//   reset_n           asynchronous active-low reset
//   fifo_rd_data      FIFO head word, valid while fifo_empty is low
//   fifo_empty        FIFO empty flag
//   fifo_almost_empty FIFO almost-empty flag
//   fifo_rd_en        pop strobe, one word per high cycle
//   out_data          output stream word (oldest buffered entry)
//   out_valid         out_data holds a word
//   out_ready         downstream accepts the current word
//   out_last          final word of a burst, qualified by out_valid
//   busy              a burst is in progress or words are still buffered
//   burst_count       number of completed bursts, wraps at 16 bits
// -----------------------------------------------------------------------------
module fifo_burst_reader #(
  parameter int width     = 32,
  parameter int burst_len = 8,
  parameter int timeout   = 64
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [width-1:0] fifo_rd_data,
  input  logic             fifo_empty,
  input  logic             fifo_almost_empty,
  output logic             fifo_rd_en,
  output logic [width-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic [15:0]      burst_count
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam logic [7:0]  full_size   = 8'(burst_len);
  localparam logic [15:0] timer_limit = 16'(timeout - 1);

  state_t           state;
  state_t           state_next;

  logic [7:0]       issued;
  logic [7:0]       size;
  logic [15:0]      idle_timer;

  // entry 0 is always the oldest word and drives the output directly
  logic [width-1:0] data0;
  logic [width-1:0] data1;
  logic             last0;
  logic             last1;
  logic [1:0]       occupancy;

  logic             xfer;
  logic             pop_last;
  logic             start_full;
  logic             start_single;

  assign out_valid = (occupancy != 2'd0);
  assign out_data  = data0;
  assign out_last  = out_valid & last0;
  assign busy      = (state != IDLE) || out_valid;
  assign xfer      = out_valid && out_ready;
  assign pop_last  = (issued == size - 8'd1);

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and pop strobe. The almost-empty trigger is checked first so
  // a full burst is preferred over a timeout flush when both are possible.
  // A burst only finishes once its last-marked word has left the buffer, so
  // pops for the following burst can never overtake it.
  always_comb begin
    state_next   = state;
    start_full   = 1'b0;
    start_single = 1'b0;
    fifo_rd_en   = 1'b0;

    case (state)
      IDLE: begin
        if (!fifo_almost_empty) begin
          start_full = 1'b1;
        end else if (!fifo_empty && (idle_timer == timer_limit)) begin
          start_single = 1'b1;
        end
        if (start_full || start_single) begin
          state_next = BURST;
        end
      end

      BURST: begin
        fifo_rd_en = !fifo_empty && (occupancy != 2'd2) && (issued < size);
        if (fifo_rd_en && pop_last) begin
          state_next = DRAIN;
        end
      end

      DRAIN: begin
        if (xfer && last0) begin
          state_next = IDLE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Burst bookkeeping: the idle timer only runs in IDLE, and both it and the
  // issued counter are cleared when a burst is launched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      issued     <= 8'd0;
      size       <= 8'd0;
      idle_timer <= 16'd0;
    end else if (state == IDLE) begin
      if (start_full || start_single) begin
        issued     <= 8'd0;
        idle_timer <= 16'd0;
        size       <= start_full ? full_size : 8'd1;
      end else if (fifo_empty) begin
        idle_timer <= 16'd0;
      end else begin
        idle_timer <= idle_timer + 16'd1;
      end
    end else if (fifo_rd_en) begin
      issued <= issued + 8'd1;
    end
  end

  // Completed-burst counter, advanced when the last word of a burst leaves.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      burst_count <= 16'd0;
    end else if ((state == DRAIN) && xfer && last0) begin
      burst_count <= burst_count + 16'd1;
    end
  end

  // Output buffer. A pop writes into the first free slot; a transfer shifts
  // entry 1 down into entry 0. When both happen together with one word held,
  // the new word replaces the departing one so throughput stays at one word
  // per cycle. A pop is never issued with both slots full.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data0     <= '0;
      data1     <= '0;
      last0     <= 1'b0;
      last1     <= 1'b0;
      occupancy <= 2'd0;
    end else begin
      case ({fifo_rd_en, xfer})
        2'b10: begin
          if (occupancy == 2'd0) begin
            data0 <= fifo_rd_data;
            last0 <= pop_last;
          end else begin
            data1 <= fifo_rd_data;
            last1 <= pop_last;
          end
          occupancy <= occupancy + 2'd1;
        end

        2'b01: begin
          data0     <= data1;
          last0     <= last1;
          occupancy <= occupancy - 2'd1;
        end

        2'b11: begin
          data0 <= fifo_rd_data;
          last0 <= pop_last;
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_burst_reader.sv
// -----------------------------------------------------------------------------
// tb_fifo_burst_reader
//
// Directed bench for fifo_burst_reader with default parameters (32-bit words,
// 8-word bursts, 64-cycle timeout). A queue models the FIFO and a scoreboard
// queue holds the {last, word} pairs expected on the output stream.
// -----------------------------------------------------------------------------
module tb_fifo_burst_reader;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [W-1:0]  fifo_rd_data;
  logic          fifo_empty;
  logic          fifo_almost_empty;
  logic          fifo_rd_en;
  logic [W-1:0]  out_data;
  logic          out_valid;
  logic          out_ready;
  logic          out_last;
  logic          busy;
  logic [15:0]   burst_count;

  int            checks   = 0;
  int            failures = 0;
  int            pops     = 0;
  int            p0;
  logic          any_pop;
  logic [W:0]    exp_entry;

  logic [W-1:0]  fifo_q[$];
  logic [W:0]    exp_q[$];

  always #5 clk = ~clk;

  fifo_burst_reader dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .fifo_rd_data      (fifo_rd_data),
    .fifo_empty        (fifo_empty),
    .fifo_almost_empty (fifo_almost_empty),
    .fifo_rd_en        (fifo_rd_en),
    .out_data          (out_data),
    .out_valid         (out_valid),
    .out_ready         (out_ready),
    .out_last          (out_last),
    .busy              (busy),
    .burst_count       (burst_count)
  );

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic update_fifo();
    fifo_empty   = (fifo_q.size() == 0);
    fifo_rd_data = fifo_empty ? '0 : fifo_q[0];
  endtask

  // inputs change 2 time units after the edge, after the FIFO model pops
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic apply_stimulus(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) fifo_q.push_back(base + W'(i));
    update_fifo();
  endtask

  task automatic expect_burst(input logic [W-1:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back({(i == n - 1), base + W'(i)});
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while (busy && n < budget) begin
      tick();
      n++;
    end
    check_output("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic full_burst(input logic [W-1:0] base, input int count_after);
    apply_stimulus(base, 8);
    expect_burst(base, 8);
    fifo_almost_empty = 1'b0;
    tick();
    fifo_almost_empty = 1'b1;
    for (int i = 0; i < 8; i++) begin
      check_output("burst_pop", 64'(fifo_rd_en), 64'd1);
      tick();
    end
    check_output("burst_pop_end", 64'(fifo_rd_en), 64'd0);
    wait_idle(50);
    check_output("burst_count", 64'(burst_count), 64'(count_after));
    check_output("scoreboard_drained", 64'(exp_q.size()), 64'd0);
  endtask

  // FIFO model: pop the head shortly after each edge on which the reader
  // strobed fifo_rd_en
  always begin
    @(posedge clk);
    if (fifo_rd_en) begin
      pops++;
      #1;
      if (fifo_q.size() != 0) void'(fifo_q.pop_front());
      update_fifo();
    end
  end

  // Output monitor: every accepted word is matched against the scoreboard
  always @(negedge clk) begin
    if (reset_n) begin
      if (fifo_empty) check_output("rd_en_while_empty", 64'(fifo_rd_en), 64'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_word", 64'(exp_q.size()), 64'd1);
        end else begin
          exp_entry = exp_q.pop_front();
          check_output("out_data", 64'(out_data), 64'(exp_entry[W-1:0]));
          check_output("out_last", 64'(out_last), 64'(exp_entry[W]));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n           = 1'b0;
    out_ready         = 1'b1;
    fifo_almost_empty = 1'b1;
    update_fifo();

    // Reset state
    #12;
    check_output("reset_rd_en", 64'(fifo_rd_en), 64'd0);
    check_output("reset_out_valid", 64'(out_valid), 64'd0);
    check_output("reset_out_last", 64'(out_last), 64'd0);
    check_output("reset_out_data", 64'(out_data), 64'd0);
    check_output("reset_busy", 64'(busy), 64'd0);
    check_output("reset_burst_count", 64'(burst_count), 64'd0);
    tick();
    reset_n = 1'b1;
    tick();
    check_output("no_pop_after_reset", 64'(fifo_rd_en), 64'd0);

    // Full burst with free-flowing output
    full_burst(32'h0, 1);

    // Backpressure: only two words fit before pops stop
    out_ready = 1'b0;
    apply_stimulus(32'h10, 8);
    expect_burst(32'h10, 8);
    fifo_almost_empty = 1'b0;
    tick();
    fifo_almost_empty = 1'b1;
    p0 = pops;
    check_output("bp_pop0", 64'(fifo_rd_en), 64'd1);
    tick();
    check_output("bp_pop1", 64'(fifo_rd_en), 64'd1);
    tick();
    for (int i = 0; i < 3; i++) begin
      check_output("bp_stalled", 64'(fifo_rd_en), 64'd0);
      check_output("bp_valid", 64'(out_valid), 64'd1);
      check_output("bp_held_data", 64'(out_data), 64'h10);
      check_output("bp_held_last", 64'(out_last), 64'd0);
      tick();
    end
    check_output("bp_pop_count", 64'(pops - p0), 64'd2);
    out_ready = 1'b1;
    wait_idle(50);
    check_output("bp_total_pops", 64'(pops - p0), 64'd8);
    check_output("bp_burst_count", 64'(burst_count), 64'd2);
    check_output("bp_drained", 64'(exp_q.size()), 64'd0);

    // Timeout flush of a single straggler word
    apply_stimulus(32'hA5, 1);
    exp_q.push_back({1'b1, 32'hA5});
    p0      = pops;
    any_pop = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (fifo_rd_en) any_pop = 1'b1;
      tick();
    end
    check_output("timeout_quiet", 64'(any_pop), 64'd0);
    check_output("timeout_pop", 64'(fifo_rd_en), 64'd1);
    wait_idle(20);
    check_output("timeout_pop_count", 64'(pops - p0), 64'd1);
    check_output("timeout_burst_count", 64'(burst_count), 64'd3);

    // Underrun: burst stalls after 3 words and resumes when data returns
    apply_stimulus(32'h20, 3);
    expect_burst(32'h20, 8);
    fifo_almost_empty = 1'b0;
    tick();
    fifo_almost_empty = 1'b1;
    p0 = pops;
    repeat (8) tick();
    check_output("underrun_pops", 64'(pops - p0), 64'd3);
    check_output("underrun_rd_en", 64'(fifo_rd_en), 64'd0);
    check_output("underrun_valid", 64'(out_valid), 64'd0);
    check_output("underrun_busy", 64'(busy), 64'd1);
    check_output("underrun_burst_count", 64'(burst_count), 64'd3);
    apply_stimulus(32'h23, 5);
    wait_idle(50);
    check_output("underrun_total_pops", 64'(pops - p0), 64'd8);
    check_output("underrun_burst_done", 64'(burst_count), 64'd4);
    check_output("underrun_drained", 64'(exp_q.size()), 64'd0);

    // Reset in the middle of a burst
    apply_stimulus(32'h30, 8);
    expect_burst(32'h30, 8);
    fifo_almost_empty = 1'b0;
    tick();
    fifo_almost_empty = 1'b1;
    p0 = pops;
    for (int n = 0; n < 20 && (pops - p0) < 4; n++) tick();
    check_output("mid_pops", 64'(pops - p0), 64'd4);
    check_output("mid_consumed", 64'(exp_q.size()), 64'd5);
    reset_n = 1'b0;
    #1;
    check_output("mid_reset_valid", 64'(out_valid), 64'd0);
    check_output("mid_reset_rd_en", 64'(fifo_rd_en), 64'd0);
    check_output("mid_reset_last", 64'(out_last), 64'd0);
    check_output("mid_reset_busy", 64'(busy), 64'd0);
    check_output("mid_reset_count", 64'(burst_count), 64'd0);
    fifo_q.delete();
    exp_q.delete();
    update_fifo();
    tick();
    tick();
    reset_n = 1'b1;
    tick();
    check_output("post_reset_no_pop", 64'(fifo_rd_en), 64'd0);
    check_output("post_reset_valid", 64'(out_valid), 64'd0);
    full_burst(32'h40, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 SHALL have parameter width, default 32, meaning data word width in bits.
REQ-002 SHALL have parameter burst_len, default 8, meaning words per full burst (legal 1..255).
REQ-003 SHALL have parameter timeout, default 64, meaning idle cycles with a non-empty FIFO before a 1-word burst is forced (legal 1..65535).
REQ-004 SHALL have port clk  in  1  the single clock; all state changes on its rising edge.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port fifo_rd_data  in  width  FIFO head word; valid combinationally while fifo_empty=0.
REQ-007 SHALL have port fifo_empty  in  1  FIFO empty flag.
REQ-008 SHALL have port fifo_almost_empty  in  1  FIFO almost-empty flag.
REQ-009 SHALL have port fifo_rd_en  out  1  pop strobe to FIFO; one word per high cycle.
REQ-010 SHALL have port out_data  out  width  output stream word.
REQ-011 SHALL have port out_valid  out  1  out_data valid.
REQ-012 SHALL have port out_ready  in  1  downstream accepts; transfer when out_valid=1 and out_ready=1.
REQ-013 SHALL have port out_last  out  1  marks final word of a burst; qualified by out_valid.
REQ-014 SHALL have port busy  out  1  high when state!=IDLE or out_valid=1.
REQ-015 SHALL have port burst_count  out  16  completed bursts, wraps 65535->0.

Function
REQ-016 SHALL hold a 2-entry output buffer; each entry stores {word, last}; out_valid=(occupancy>0); out_data/out_last=oldest entry.
REQ-017 SHALL drive fifo_rd_en combinationally = (state==BURST) and fifo_empty=0 and occupancy<2 and issued<size.
REQ-018 SHALL on a pop cycle capture fifo_rd_data into the buffer at that edge; word appears on out_data no earlier than next cycle (1-cycle latency when buffer empty).
REQ-019 SHALL set the captured entry's last bit when issued==size-1 at pop time.
REQ-020 SHALL allow pop and downstream transfer in the same cycle (occupancy unchanged), sustaining 1 word/cycle.
REQ-021 SHALL never assert fifo_rd_en while fifo_empty=1 and SHALL hold out_data/out_last stable while out_valid=1 and out_ready=0.
REQ-022 SHALL implement states IDLE, BURST, DRAIN.
REQ-023 IDLE: 16-bit idle timer increments each cycle fifo_empty=0, clears when fifo_empty=1; fifo_almost_empty=0 -> BURST with size=burst_len; else timer reaching timeout-1 with fifo_empty=0 -> BURST with size=1; almost-empty path wins if both.
REQ-024 Entering BURST SHALL clear issued counter and idle timer.
REQ-025 BURST: FIFO going empty mid-burst SHALL stall pops (no abort); issued==size after a pop -> DRAIN.
REQ-026 DRAIN: when the last-marked entry transfers -> IDLE and burst_count increments by 1 on that edge.
REQ-027 Only IDLE SHALL start a new burst; pops for burst N+1 never interleave with burst N.

Reset
REQ-028 SHALL on reset_n=0 immediately force state IDLE, buffer empty, issued, idle timer, burst_count = 0.
REQ-029 SHALL during reset drive fifo_rd_en=0, out_valid=0, out_last=0, out_data=0, busy=0.
REQ-030 Reset mid-burst SHALL discard buffered words; no pop on the first edge after reset_n rises.

Verification
REQ-031 Full burst: FIFO holds 8 words 0..7, almost_empty=0, out_ready=1 -> 8 pops on consecutive cycles, out_data 0..7 back-to-back, out_last only on 7, burst_count 0->1.
REQ-032 Backpressure: out_ready=0 during full burst -> exactly 2 pops then fifo_rd_en=0, out_data held at word 0; out_ready=1 -> remaining 6 words in order, none lost or duplicated.
REQ-033 Timeout: 1 word 0xA5, almost_empty=1 held -> no pop for 63 cycles, then 1-word burst 0xA5 with out_last=1, burst_count=1.
REQ-034 Underrun: full burst begins with 3 words, FIFO empty afterwards -> stall after word 2, out_last not asserted; 5 more words pushed -> burst resumes, out_last on 8th word.
REQ-035 Reset mid-burst: reset_n low after 4 of 8 pops -> out_valid=0, fifo_rd_en=0 at once, burst_count=0; after release behaviour restarts from IDLE.
